// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, HI/LO registers.
// Optional MDU_DIV_ZERO_DETECT_EN: early finish on divide-by-zero plus a div_zero flag.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
`ifdef MDU_DIV_ZERO_DETECT_EN
    output logic                  div_zero,
`endif
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  mag_b;
    logic          is_div;
    logic          neg_q;
    logic          neg_r;
`ifdef MDU_DIV_ZERO_DETECT_EN
    logic          dz_pend;
`endif

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
    logic         signed_op;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & src_a[W-1];
    assign b_neg     = signed_op & src_b[W-1];
    assign a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag     = b_neg ? (~src_b + 1'b1) : src_b;

    // Multiply step: acc_lo holds the unconsumed multiplier bits, product shifts in from the top.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(W+1){1'b0}});

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [W:0]   div_shift;
    logic [W+1:0] div_diff;
    logic         div_borrow;
    assign div_shift  = {acc_hi, acc_lo[W-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, mag_b};
    assign div_borrow = div_diff[W+1];

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    assign prod_fix = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    assign quot_fix = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            dz_pend  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            mag_b  <= b_mag;
                            is_div <= op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            cnt    <= '0;
                            state  <= S_CALC;
`ifdef MDU_DIV_ZERO_DETECT_EN
                            dz_pend <= 1'b0;
                            // Preload exactly what the full iteration would leave behind.
                            if (op[1] && (src_b == '0)) begin
                                acc_hi  <= a_mag;
                                acc_lo  <= '1;
                                dz_pend <= 1'b1;
                                state   <= S_FINISH;
                            end
`endif
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc_hi <= div_borrow ? div_shift[W-1:0] : div_diff[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], ~div_borrow};
                    end else begin
                        acc_hi <= mul_sum[W:1];
                        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                    end
                    if (cnt == CW'(W-1)) begin
                        cnt   <= '0;
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
`ifdef MDU_DIV_ZERO_DETECT_EN
                    div_zero <= dz_pend;
                    dz_pend  <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/latency, a monitor pops on done.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;
`ifdef MDU_DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
    assign div_zero = 1'b0;
`endif

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
`ifdef MDU_DIV_ZERO_DETECT_EN
        .div_zero (div_zero),
`endif
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef MDU_DIV_ZERO_DETECT_EN
                chk("div_zero", 64'(div_zero), 64'(e.dz));
`endif
            end
        end
`ifdef MDU_DIV_ZERO_DETECT_EN
        if (rst_n && div_zero && !done) chk("div_zero_without_done", 64'd1, 64'd0);
`endif
    end

    function automatic exp_t mk(input logic [W-1:0] eh, el, input bit dz, input int c);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = dz; e.cyc = c;
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b, eh, el,
                         input bit dz, input int lat);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        q.push_back(mk(eh, el, dz, cyc + 1 + lat));
        @(negedge clk);
        start = 1'b0;
        src_a = ~a; src_b = ~b;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy || q.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        if (busy || q.size() != 0) chk("timeout_waiting_done", 64'd1, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // MTHI / MTLO: single-edge writes, no busy, no done
        start = 1'b1; op = 3'b100; src_a = 32'hAAAA0000;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hAAAA0000);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        start = 1'b1; op = 3'b101; src_a = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h5555);
        chk("mtlo_hi_held", 64'(hi), 64'hAAAA0000);
        chk("mtlo_done", 64'(done), 64'd0);
        // Undefined op is a no-op
        start = 1'b1; op = 3'b111; src_a = 32'h1;
        @(negedge clk);
        start = 1'b0;
        chk("nop_busy", 64'(busy), 64'd0);
        chk("nop_lo", 64'(lo), 64'h5555);

        // Reset mid-CALC of MULTU 5*6 aborts with no write
        start = 1'b1; op = 3'b001; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_idle_lo", 64'(lo), 64'd0);

        // Multiplies
        issue(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, W + 1);
        wait_idle();
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W + 1);
        wait_idle();

        // Divides
        issue(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 1);
        wait_idle();
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, W + 1);
        wait_idle();
        issue(3'b011, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, DZ, DZ ? 1 : W + 1);
        wait_idle();

        // DIVU 100/7 with an MTLO attempt while busy
        issue(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b101; src_a = 32'h1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("mtlo_ignored_lo", 64'(lo), 64'd14);
        chk("mtlo_ignored_hi", 64'(hi), 64'd2);

        // Back-to-back: start held across done; second op sees operands changed mid-CALC
        @(negedge clk);
        start = 1'b1; op = 3'b001; src_a = 32'd3; src_b = 32'd4;
        q.push_back(mk(32'd0, 32'd12, 1'b0, cyc + 1 + W + 1));
        q.push_back(mk(32'd0, 32'd56, 1'b0, cyc + 1 + (W + 2) + W + 1));
        @(negedge clk);
        src_a = 32'd7; src_b = 32'd8;
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
